// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter for the SPI transmit path. A one-entry holding
// buffer lets the next word stream in behind the current one without a gap.
module piso_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  lsb_first,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  shift_en,
    input  logic                  flush,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  frame_start,
    output logic                  done_tick,
    output logic                  busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shifter;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [CNT_W-1:0]      cnt;
    logic                  mode;
    logic                  hold_lsb;
    logic                  hold_full;

    logic accept, consume, last_bit, load_word;

    assign accept    = load_valid && !hold_full && !flush;
    assign consume   = (state == SHIFT) && shift_en;
    assign last_bit  = consume && (cnt == LAST_CNT);
    // The held word moves into the shifter when idle or right as the last bit leaves.
    assign load_word = !flush && hold_full && ((state == IDLE) || last_bit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: defaults first so no path through the block leaves a latch behind.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (hold_full) state_next = SHIFT;
                SHIFT:   if (last_bit && !hold_full) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        serial_valid = (state == SHIFT);
        load_ready   = !hold_full;
        busy         = (state == SHIFT) || hold_full;
        serial_out   = mode ? shifter[0] : shifter[DATA_WIDTH-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data <= '0;
            hold_lsb  <= 1'b0;
            hold_full <= 1'b0;
        end else if (flush) begin
            hold_data <= '0;
            hold_lsb  <= 1'b0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= data_in;
            hold_lsb  <= lsb_first;
            hold_full <= 1'b1;
        end else if (load_word) begin
            hold_full <= 1'b0;
        end
    end

    // Bit order travels with the word via mode, so the pin can change freely mid-word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shifter     <= '0;
            cnt         <= '0;
            mode        <= 1'b0;
            frame_start <= 1'b0;
            done_tick   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done_tick   <= 1'b0;
            if (flush) begin
                shifter <= '0;
                cnt     <= '0;
                mode    <= 1'b0;
            end else if (load_word) begin
                shifter     <= hold_data;
                mode        <= hold_lsb;
                cnt         <= '0;
                frame_start <= 1'b1;
                done_tick   <= last_bit;
            end else if (last_bit) begin
                shifter   <= '0;
                cnt       <= '0;
                mode      <= 1'b0;
                done_tick <= 1'b1;
            end else if (consume) begin
                shifter <= mode ? (shifter >> 1) : (shifter << 1);
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (DATA_WIDTH=8): a cycle model tracks
// framing/handshake and a bit queue scoreboard tracks the expected serial stream.
module tb_piso_serializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          lsb_first;
    logic          load_valid;
    logic          load_ready;
    logic          shift_en;
    logic          flush;
    logic          serial_out;
    logic          serial_valid;
    logic          frame_start;
    logic          done_tick;
    logic          busy;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .lsb_first   (lsb_first),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .shift_en    (shift_en),
        .flush       (flush),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .frame_start (frame_start),
        .done_tick   (done_tick),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state and scoreboard
    bit            m_shift, m_hold, exp_frame, exp_done;
    int            m_cnt;
    logic          bit_q[$];
    logic          prev_so = 1'b0;
    logic [DW-1:0] rx_word = '0;
    int            n_valid, n_done, n_frame, n_coinc, n_accept;

    // Inputs change at negedge+1, so at negedge they still show what the last posedge used.
    always @(negedge clk) begin
        bit acc;
        acc = 1'b0;
        if (!reset || flush) begin
            m_shift   = 1'b0;
            m_hold    = 1'b0;
            m_cnt     = 0;
            exp_frame = 1'b0;
            exp_done  = 1'b0;
            bit_q.delete();
        end else begin
            exp_frame = 1'b0;
            exp_done  = 1'b0;
            acc       = load_valid && !m_hold;
            if (!m_shift) begin
                if (m_hold) begin
                    m_shift   = 1'b1;
                    m_hold    = 1'b0;
                    m_cnt     = 0;
                    exp_frame = 1'b1;
                end
            end else if (shift_en) begin
                if (bit_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else begin
                    check("consumed_bit", prev_so, bit_q[0]);
                    void'(bit_q.pop_front());
                end
                rx_word = {rx_word[DW-2:0], prev_so};
                if (m_cnt == DW - 1) begin
                    exp_done = 1'b1;
                    m_cnt    = 0;
                    if (m_hold) begin
                        m_hold    = 1'b0;
                        exp_frame = 1'b1;
                    end else begin
                        m_shift = 1'b0;
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (acc) begin
                m_hold = 1'b1;
                n_accept++;
                for (int i = 0; i < DW; i++)
                    bit_q.push_back(lsb_first ? data_in[i] : data_in[DW-1-i]);
            end
        end
        check("serial_valid", serial_valid, m_shift);
        check("busy", busy, m_shift | m_hold);
        check("load_ready", load_ready, !m_hold);
        check("frame_start", frame_start, exp_frame);
        check("done_tick", done_tick, exp_done);
        if (m_shift) begin
            if (bit_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
            else                   check("serial_out", serial_out, bit_q[0]);
        end else begin
            check("serial_out_idle", serial_out, 1'b0);
        end
        if (serial_valid)              n_valid++;
        if (done_tick)                 n_done++;
        if (frame_start)               n_frame++;
        if (frame_start && done_tick)  n_coinc++;
        prev_so = serial_out;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        n_valid  = 0;
        n_done   = 0;
        n_frame  = 0;
        n_coinc  = 0;
        n_accept = 0;
        rx_word  = '0;
    endtask

    task automatic drain();
        int k;
        k          = 0;
        load_valid = 1'b0;
        while (busy && k < 400) begin
            shift_en = (k % 4 == 3);
            cyc();
            k++;
        end
        if (busy) check("drain_timeout", 32'd1, 32'd0);
        shift_en = 1'b0;
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        data_in    = '0;
        lsb_first  = 1'b0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        flush      = 1'b0;
        clr_counts();
        cyc(3);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        cyc(2);

        // MSB-first 0x1E, strobe every cycle
        clr_counts();
        data_in = 8'h1E; lsb_first = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
        cyc();
        load_valid = 1'b0;
        cyc(12);
        check("t1_valid_cycles", n_valid, 8);
        check("t1_done_count", n_done, 1);
        check("t1_frame_count", n_frame, 1);
        check("t1_word", rx_word, 8'h1E);

        // LSB-first 0x1E with the mode pin toggling mid-word
        clr_counts();
        data_in = 8'h1E; lsb_first = 1'b1; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            lsb_first = ~lsb_first;
            cyc();
        end
        check("t2_word", rx_word, 8'h78);
        check("t2_done_count", n_done, 1);

        // Back-to-back words: second accept after 3 bits
        clr_counts();
        data_in = 8'h1E; lsb_first = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
        cyc();
        load_valid = 1'b0;
        cyc(4);
        data_in = 8'hF0; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        check("t3_ready_after_accept", load_ready, 1'b0);
        cyc(20);
        check("t3_valid_cycles", n_valid, 16);
        check("t3_done_count", n_done, 2);
        check("t3_frame_count", n_frame, 2);
        check("t3_coincide", n_coinc, 1);
        check("t3_second_word", rx_word, 8'hF0);

        // Sparse strobes with load_valid held high and changing data
        clr_counts();
        lsb_first = 1'b0; load_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            shift_en = (c % 4 == 3);
            data_in  = 8'(c * 37 + 11);
            cyc();
        end
        drain();
        check("t4_frames_eq_accepts", n_frame, n_accept);
        check("t4_dones_eq_accepts", n_done, n_accept);
        check("t4_multi_accept", n_accept > 2, 1'b1);

        // Flush with a word pending after 3 strobes
        clr_counts();
        shift_en = 1'b1;
        data_in = 8'h3C; load_valid = 1'b1;
        cyc();
        data_in = 8'h99;
        cyc(2);
        load_valid = 1'b0;
        cyc(2);
        flush = 1'b1;
        cyc();
        check("t5_valid", serial_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_ready", load_ready, 1'b1);
        flush = 1'b0; shift_en = 1'b0;
        cyc(3);
        check("t5_no_done", n_done, 0);
        check("t5_frame_count", n_frame, 1);

        // Reset mid-word, then a fresh word
        clr_counts();
        data_in = 8'h5A; load_valid = 1'b1; shift_en = 1'b1;
        cyc();
        load_valid = 1'b0;
        cyc(4);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_valid", serial_valid, 1'b0);
        check("t6_rst_out", serial_out, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ready", load_ready, 1'b1);
        check("t6_rst_frame", frame_start, 1'b0);
        check("t6_rst_done", done_tick, 1'b0);
        cyc(2);
        reset = 1'b1;
        clr_counts();
        data_in = 8'hA5; lsb_first = 1'b0; load_valid = 1'b1; shift_en = 1'b1;
        cyc();
        load_valid = 1'b0;
        cyc(12);
        check("t6_word", rx_word, 8'hA5);
        check("t6_done_count", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
